// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel arbiter slice: screen bounds, colours, pixel struct, FSM state.
package pixel_pkg;

  localparam int XW        = 9;
  localparam int YW        = 8;
  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;

  localparam logic [2:0] BLACK   = 3'd0;
  localparam logic [2:0] BLUE    = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] CYAN    = 3'd3;
  localparam logic [2:0] RED     = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] YELLOW  = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;

  typedef struct packed {
    logic signed [XW-1:0] x;
    logic signed [YW-1:0] y;
    logic [2:0]           colour;
  } pixel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } arb_state_e;

  // Observation bundle: arbiter FSM state and last-granted channel.
  typedef struct packed {
    arb_state_e state;
    logic       rr_last;
  } arb_dbg_t;

endpackage

// File: rtl/pixel_arbiter_rr_arb2.sv
// Two-input arbiter with last-grant register. Round-robin by default;
// PIXEL_ARB_PRIO_EN makes channel 1 win whenever both request.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o,
  output logic       last_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
`ifdef PIXEL_ARB_PRIO_EN
        2'b11:   grant_o = 2'b10;
`else
        // last_q=1 means channel 1 was served last, so channel 0 goes next.
        2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
`endif
        default: grant_o = 2'b00;
      endcase
    end
    last_d = (grant_o != 2'b00) ? grant_o[1] : last_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/pixel_arbiter.sv
// Merges fill/circle pixel streams into one registered vga_adapter port with off-screen clipping.
// Define PIXEL_ARB_PRIO_EN for fixed priority (circle wins) instead of round-robin.
import pixel_pkg::*;

module pixel_arbiter #(
  parameter int SCR_W = SCR_W_DEF,
  parameter int SCR_H = SCR_H_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*XW-1:0] req_x,
  input  logic [2*YW-1:0] req_y,
  input  logic [5:0]      req_colour,
  input  logic            hold,
  output logic [7:0]      vga_x,
  output logic [6:0]      vga_y,
  output logic [2:0]      vga_colour,
  output logic            vga_plot,
  output logic [15:0]     clip_cnt,
  output arb_dbg_t        dbg_o
);

  localparam logic [XW-1:0] X_LIM = XW'(SCR_W);
  localparam logic [YW-1:0] Y_LIM = YW'(SCR_H);

  // Handshake: a channel's pixel is consumed at the posedge where req_valid[i] & req_ready[i];
  // at most one ready bit is high, and none while hold or rst is asserted.
  logic [1:0] grant;
  logic       rr_last;
  logic       accept;
  logic       in_bounds;
  pixel_t     pix0, pix1, sel;

  arb_state_e  state_q, state_d;
  logic        plot_q, plot_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  col_q, col_d;
  logic [15:0] clip_q, clip_d;

  rr_arb2 u_arb (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (!hold && !rst),
    .valid_i (req_valid),
    .grant_o (grant),
    .last_o  (rr_last)
  );

  assign pix0   = {req_x[XW-1:0],    req_y[YW-1:0],    req_colour[2:0]};
  assign pix1   = {req_x[2*XW-1:XW], req_y[2*YW-1:YW], req_colour[5:3]};
  assign sel    = grant[1] ? pix1 : pix0;
  assign accept = |grant;

  // Negative coordinates have the sign bit set; the rest is an unsigned range check.
  assign in_bounds = !sel.x[XW-1] && ($unsigned(sel.x) < X_LIM) &&
                     !sel.y[YW-1] && ($unsigned(sel.y) < Y_LIM);

  always_comb begin
    state_d = state_q;
    plot_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    clip_d  = clip_q;

    case (state_q)
      ST_IDLE: if (|req_valid && !hold) state_d = ST_PASS;
      ST_PASS: if (!(|req_valid) || hold) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      if (in_bounds) begin
        plot_d = 1'b1;
        x_d    = sel.x[7:0];
        y_d    = sel.y[6:0];
        col_d  = sel.colour;
      end else if (clip_q != 16'hFFFF) begin
        clip_d = clip_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      clip_q  <= '0;
    end else begin
      state_q <= state_d;
      plot_q  <= plot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      clip_q  <= clip_d;
    end
  end

  assign req_ready  = grant;
  assign vga_plot   = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = col_q;
  assign clip_cnt   = clip_q;
  assign dbg_o      = '{state: state_q, rr_last: rr_last};

endmodule

// File: tb/tb_pixel_arbiter.sv
// Directed bench for pixel_arbiter: behavioural model + per-cycle compare, plus literal spot checks.
module tb_pixel_arbiter;
  import pixel_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [2*XW-1:0] req_x = '0;
  logic [2*YW-1:0] req_y = '0;
  logic [5:0]      req_colour = '0;
  logic            hold = 1'b0;
  logic [7:0]      vga_x;
  logic [6:0]      vga_y;
  logic [2:0]      vga_colour;
  logic            vga_plot;
  logic [15:0]     clip_cnt;
  arb_dbg_t        dbg_o;

  pixel_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .hold(hold),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .clip_cnt(clip_cnt), .dbg_o(dbg_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: channel numbers, signed ints, one queue entry per clock
  int  m_last = 1, m_plot = 0, m_x = 0, m_y = 0, m_col = 0, m_clip = 0, m_pass = 0;
  bit  model_ok = 1'b0;
  int  g, px, py;
  logic [34:0] exp_q[$];
  logic [34:0] e;

  function automatic int pick();
    if (rst || hold) return -1;
    if (req_valid == 2'b11) begin
`ifdef PIXEL_ARB_PRIO_EN
      return 1;
`else
      return 1 - m_last;
`endif
    end
    if (req_valid[0]) return 0;
    if (req_valid[1]) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_last = 1; m_plot = 0; m_x = 0; m_y = 0; m_col = 0; m_clip = 0; m_pass = 0;
      model_ok = 1'b1;
    end else begin
      g = pick();
      m_plot = 0;
      m_pass = (req_valid != 2'b00 && !hold) ? 1 : 0;
      if (g >= 0) begin
        px = int'($signed(req_x[g*XW +: XW]));
        py = int'($signed(req_y[g*YW +: YW]));
        if (px >= 0 && px < SCR_W_DEF && py >= 0 && py < SCR_H_DEF) begin
          m_plot = 1; m_x = px; m_y = py; m_col = int'(req_colour[g*3 +: 3]);
        end else begin
          m_clip = (m_clip < 65535) ? m_clip + 1 : 65535;
        end
        m_last = g;
      end
    end
    if (model_ok) exp_q.push_back({m_plot[0], m_x[7:0], m_y[6:0], m_col[2:0], m_clip[15:0]});
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("m_plot",   int'(vga_plot),   int'(e[34]));
      chk("m_x",      int'(vga_x),      int'(e[33:26]));
      chk("m_y",      int'(vga_y),      int'(e[25:19]));
      chk("m_colour", int'(vga_colour), int'(e[18:16]));
      chk("m_clip",   int'(clip_cnt),   int'(e[15:0]));
    end
    if (model_ok) begin
      g = pick();
      chk("m_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
      chk("m_state", int'(dbg_o.state), m_pass);
    end
  end

  // driver tasks: inputs change 1 unit after the posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v,
                       input int x0, input int y0, input logic [2:0] c0,
                       input int x1, input int y1, input logic [2:0] c1);
    req_valid  = v;
    req_x      = {XW'(x1), XW'(x0)};
    req_y      = {YW'(y1), YW'(y0)};
    req_colour = {c1, c0};
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; hold = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int t2_x[4];
  int t2_rdy[4];

  initial begin
`ifdef PIXEL_ARB_PRIO_EN
    t2_x = '{2, 2, 2, 2};  t2_rdy = '{2, 2, 2, 2};
`else
    t2_x = '{1, 2, 1, 2};  t2_rdy = '{1, 2, 1, 2};
`endif
    // reset state, including no accepts while rst=1
    rst = 1'b1;
    repeat (3) tick();
    drive(2'b11, 1, 1, GREEN, 2, 2, BLUE);
    #1;
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_clip", int'(clip_cnt), 0);
    chk("rst_x", int'(vga_x), 0);
    req_valid = 2'b00;
    rst = 1'b0;
    tick();

    // 1: single ch0 pixel
    drive(2'b01, 5, 7, RED, 0, 0, BLACK);
    #1 chk("t1_ready", int'(req_ready), 1);
    tick();
    req_valid = 2'b00;
    chk("t1_plot", int'(vga_plot), 1);
    chk("t1_x", int'(vga_x), 5);
    chk("t1_y", int'(vga_y), 7);
    chk("t1_colour", int'(vga_colour), 4);
    tick();
    chk("t1_plot_pulse", int'(vga_plot), 0);
    chk("t1_x_hold", int'(vga_x), 5);

    // 2: both valid for 4 cycles
    do_reset();
    drive(2'b11, 1, 1, GREEN, 2, 2, BLUE);
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_ready", int'(req_ready), t2_rdy[i]);
      tick();
      chk("t2_x", int'(vga_x), t2_x[i]);
      chk("t2_plot", int'(vga_plot), 1);
    end
    req_valid = 2'b00;
    tick();

    // 3: clipping on ch1
    do_reset();
    begin
      int cx[4];
      int cy[4];
      cx = '{-1, 160, 159, 3};
      cy = '{5, 5, 119, 120};
      for (int k = 0; k < 4; k++) begin
        drive(2'b10, 0, 0, BLACK, cx[k], cy[k], WHITE);
        #1 chk("t3_ready", int'(req_ready), 2);
        tick();
        chk("t3_plot", int'(vga_plot), (k == 2) ? 1 : 0);
      end
    end
    req_valid = 2'b00;
    chk("t3_clip", int'(clip_cnt), 3);
    chk("t3_x", int'(vga_x), 159);
    chk("t3_y", int'(vga_y), 119);
    tick();

    // 4: hold with both valid
    do_reset();
    drive(2'b11, 20, 30, WHITE, 40, 50, CYAN);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_hold_ready", int'(req_ready), 0);
      tick();
      chk("t4_hold_plot", int'(vga_plot), 0);
`ifdef PIXEL_ARB_PRIO_EN
      chk("t4_hold_x", int'(vga_x), 40);
`else
      chk("t4_hold_x", int'(vga_x), 20);
`endif
    end
    hold = 1'b0;
    #1 chk("t4_resume_ready", int'(req_ready), 2);
    tick();
    chk("t4_resume_x", int'(vga_x), 40);
    req_valid = 2'b00;
    tick();

    // 5: reset in the cycle after an accept
    drive(2'b10, 0, 0, BLACK, -5, -5, RED);
    tick();
    drive(2'b01, 10, 10, YELLOW, 0, 0, BLACK);
    #1 chk("t5_ready", int'(req_ready), 1);
    tick();
    chk("t5_plot_pre", int'(vga_plot), 1);
    chk("t5_clip_pre", int'(clip_cnt), 1);
    rst = 1'b1;
    drive(2'b11, 30, 40, RED, 50, 60, BLUE);
    #1 chk("t5_rst_ready", int'(req_ready), 0);
    tick();
    chk("t5_plot", int'(vga_plot), 0);
    chk("t5_x", int'(vga_x), 0);
    chk("t5_y", int'(vga_y), 0);
    chk("t5_colour", int'(vga_colour), 0);
    chk("t5_clip", int'(clip_cnt), 0);
    rst = 1'b0;
`ifdef PIXEL_ARB_PRIO_EN
    #1 chk("t5_first_grant", int'(req_ready), 2);
    tick();
    chk("t5_first_x", int'(vga_x), 50);
`else
    #1 chk("t5_first_grant", int'(req_ready), 1);
    tick();
    chk("t5_first_x", int'(vga_x), 30);
`endif
    req_valid = 2'b00;
    tick();

    // 6: clip counter saturation
    do_reset();
    drive(2'b10, 0, 0, BLACK, -1, 0, WHITE);
    repeat (65540) tick();
    req_valid = 2'b00;
    chk("t6_clip_sat", int'(clip_cnt), 65535);
    tick();
    chk("t6_clip_stay", int'(clip_cnt), 65535);
    tick();
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
